serial_frame_rx: RTL and testbench

Serial frame receiver feeding the team's 4-bit serial-in shift register stage. It samples a one-bit line on a bit strobe, recognises start/data/stop framing, and assembles WIDTH data bits LSB-first, the same ordering produced by shifting in at the top bit. Completed words are presented on a one-entry valid/ready output buffer for the downstream parallel-load or shift stage. Framing violations and buffer overruns are reported as one-cycle pulses.

---
 rtl/serial_frame_rx_pkg.sv | 20 ++
 rtl/serial_rx_shifter.sv | 29 ++
 rtl/serial_frame_rx.sv | 120 ++++++++++++
 tb/tb_serial_frame_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding, line levels
// and the bit-counter width helper.
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Counter only needs to index data bits 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// LSB-first serial-in shift register with synchronous clear; exports the
// XOR of its contents for the optional parity check.
module serial_rx_shifter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic             parity
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (shift) begin
            data <= {bit_in, data[WIDTH-1:1]};
        end
    end

    assign parity = ^data;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start / WIDTH data bits (LSB first) / [even parity] /
// stop, into a one-entry valid/ready buffer. Parity enabled by SERIAL_RX_PARITY_EN.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             rx_bit,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] sr;
    logic             sr_clear;
    logic             sr_shift;
    logic             stop_good;
    logic             commit;

`ifdef SERIAL_RX_PARITY_EN
    logic sr_parity;
    logic parity_ok;
    assign stop_good = (rx_bit == STOP_LVL) && parity_ok;
`else
    logic sr_parity_unused;
    assign stop_good = (rx_bit == STOP_LVL);
`endif

    assign sr_clear = bit_en && (state == ST_IDLE) && (rx_bit == START_LVL);
    assign sr_shift = bit_en && (state == ST_DATA);
    assign commit   = bit_en && (state == ST_STOP) && stop_good;

    serial_rx_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .clear  (sr_clear),
        .shift  (sr_shift),
        .bit_in (rx_bit),
        .data   (sr),
`ifdef SERIAL_RX_PARITY_EN
        .parity (sr_parity)
`else
        .parity (sr_parity_unused)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_ok  <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A consume in the same cycle frees the slot for the new word.
            if (commit) begin
                if (!word_valid || word_ready) begin
                    word_out   <= sr;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_bit == START_LVL) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    ST_PARITY: begin
                        parity_ok <= ~(sr_parity ^ rx_bit);
                        state     <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        if (!stop_good) begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed frames plus randomized
// traffic against a frame-level buffer model. Honours SERIAL_RX_PARITY_EN.
module tb_serial_frame_rx;

    localparam int W = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en;
    logic         rx_bit;
    logic         word_ready;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         frame_err;
    logic         overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: contents of the one-entry output buffer.
    logic         m_valid;
    logic [W-1:0] m_word;
    logic         idle_tog = 1'b0;

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .rx_bit     (rx_bit),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive, update the model at the edge, compare at the negedge.
    task automatic tick(input logic en, input logic b, input logic rdy,
                        input logic stop_strobe, input logic good,
                        input logic [W-1:0] w, input string tag);
        logic exp_ferr;
        logic exp_ovr;
        bit_en     = en;
        rx_bit     = b;
        word_ready = rdy;
        @(posedge clk);
        exp_ferr = stop_strobe && !good;
        exp_ovr  = 1'b0;
        if (stop_strobe && good) begin
            if (!m_valid || rdy) begin
                m_word  = w;
                m_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check({tag, ".valid"}, word_valid, m_valid);
        check({tag, ".word"}, word_out, m_word);
        check({tag, ".ferr"}, frame_err, exp_ferr);
        check({tag, ".ovr"}, overrun, exp_ovr);
    endtask

    task automatic idle(input int n, input int rmode, input string tag);
        for (int i = 0; i < n; i++) begin
            idle_tog = ~idle_tog;
            tick(1'b0, idle_tog, pick_ready(rmode), 1'b0, 1'b0, '0, tag);
        end
    endtask

    // gap < 0 selects a random 0..2 idle cycles before each strobe.
    task automatic send_frame(input logic [W-1:0] w, input logic stop_bit,
                              input logic par_bad, input int gap,
                              input int rmode, input string tag);
        logic bits[$];
        logic good;
        int   g;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[i]);
        if (PARITY_ON) bits.push_back((^w) ^ par_bad);
        bits.push_back(stop_bit);
        good = stop_bit && !(PARITY_ON && par_bad);
        for (int k = 0; k < bits.size(); k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            idle(g, rmode, tag);
            tick(1'b1, bits[k], pick_ready(rmode), k == bits.size() - 1, good, w, tag);
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        m_valid = 1'b0;
        m_word  = '0;
        check({tag, ".valid"}, word_valid, 1'b0);
        check({tag, ".word"}, word_out, '0);
        check({tag, ".ferr"}, frame_err, 1'b0);
        check({tag, ".ovr"}, overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rw;
        logic         rstop;
        logic         rpar;

        bit_en     = 1'b0;
        rx_bit     = 1'b1;
        word_ready = 1'b0;
        m_valid    = 1'b0;
        m_word     = '0;
        @(negedge clk);
        pulse_reset("reset");
        idle(2, 2, "post_reset");

        // Basic frame, consumed immediately: valid for exactly one cycle.
        send_frame(4'b1010, 1'b1, 1'b0, 0, 1, "basic");
        idle(2, 1, "basic_idle");

        // Bad stop bit, then the receiver must accept the next frame.
        send_frame(4'b1010, 1'b0, 1'b0, 0, 1, "bad_stop");
        send_frame(4'h9, 1'b1, 1'b0, 0, 1, "after_bad");
        idle(2, 1, "after_bad_idle");

        // Overrun: second word dropped while first is held.
        send_frame(4'h3, 1'b1, 1'b0, 0, 0, "ovr_a");
        send_frame(4'hC, 1'b1, 1'b0, 0, 0, "ovr_b");
        check("ovr_hold", word_out, 4'h3);
        idle(1, 0, "ovr_wait");
        idle(2, 1, "ovr_drain");

        // Sparse strobes with the line toggling between them.
        send_frame(4'h5, 1'b1, 1'b0, 2, 1, "slow");
        idle(2, 1, "slow_idle");

        // Reset mid-frame with a buffered word present.
        send_frame(4'h6, 1'b1, 1'b0, 0, 0, "pre_rst");
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "partial");
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, "partial");
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "partial");
        pulse_reset("mid_rst");
        send_frame(4'hF, 1'b1, 1'b0, 0, 1, "after_rst");
        idle(2, 1, "after_rst_idle");

`ifdef SERIAL_RX_PARITY_EN
        send_frame(4'h7, 1'b1, 1'b0, 0, 1, "par_good");
        idle(2, 1, "par_idle");
        send_frame(4'h7, 1'b1, 1'b1, 0, 1, "par_bad");
        idle(2, 1, "par_idle2");
`endif

        // Randomized traffic: random words, occasional framing errors,
        // random strobe spacing, idle-line strobes and random back-pressure.
        for (int f = 0; f < 200; f++) begin
            rw    = W'($urandom);
            rstop = ($urandom_range(0, 7) != 0);
            rpar  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tick(1'b1, 1'b1, pick_ready(2), 1'b0, 1'b0, '0, "rnd_idle_strobe");
            end
            send_frame(rw, rstop, rpar, -1, 2, "rnd");
        end
        idle(4, 1, "final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
